// File: rtl/cmo_dcache_responder_pkg.sv
// Shared types for the D-cache CMO responder: request/response payloads,
// the op encoding and the tag/data update encoding the cache controller decodes.
package cmo_dcache_responder_pkg;

    localparam int unsigned XLEN          = 64;
    localparam int unsigned TRANS_ID_BITS = 4;

    typedef logic [XLEN-1:0] xlen_t;

    typedef enum logic [2:0] {
        CMO_NONE       = 3'd0,
        CMO_CLEAN      = 3'd1,
        CMO_FLUSH      = 3'd2,
        CMO_INVAL      = 3'd3,
        CMO_ZERO       = 3'd4,
        CMO_PREFETCH_R = 3'd5,
        CMO_PREFETCH_W = 3'd6
    } cmo_t;

    typedef struct packed {
        logic                     req;
        logic [TRANS_ID_BITS-1:0] trans_id;
        xlen_t                    address;
        cmo_t                     cmo_op;
    } cmo_req_t;

    typedef struct packed {
        logic                     req_ready;
        logic                     ack;
        logic [TRANS_ID_BITS-1:0] trans_id;
    } cmo_resp_t;

    typedef struct packed {
        logic valid;
        logic dirty;
        logic zero;
    } dcache_cmo_upd_t;

    localparam dcache_cmo_upd_t DCACHE_CMO_UPD_NONE  = '{valid: 1'b0, dirty: 1'b0, zero: 1'b0};
    localparam dcache_cmo_upd_t DCACHE_CMO_UPD_CLEAN = '{valid: 1'b1, dirty: 1'b0, zero: 1'b0};
    localparam dcache_cmo_upd_t DCACHE_CMO_UPD_INVAL = '{valid: 1'b0, dirty: 1'b0, zero: 1'b0};
    localparam dcache_cmo_upd_t DCACHE_CMO_UPD_ZERO  = '{valid: 1'b1, dirty: 1'b1, zero: 1'b1};

    // FLUSH shares the invalidate encoding: the line leaves the cache either way.
    function automatic dcache_cmo_upd_t cmo_upd_decode(input cmo_t op);
        dcache_cmo_upd_t upd;
        case (op)
            CMO_CLEAN:            upd = DCACHE_CMO_UPD_CLEAN;
            CMO_FLUSH, CMO_INVAL: upd = DCACHE_CMO_UPD_INVAL;
            CMO_ZERO:             upd = DCACHE_CMO_UPD_ZERO;
            default:              upd = DCACHE_CMO_UPD_NONE;
        endcase
        return upd;
    endfunction

    function automatic logic cmo_is_hint(input cmo_t op);
        return (op == CMO_NONE) || (op == CMO_PREFETCH_R) || (op == CMO_PREFETCH_W);
    endfunction

endpackage

// File: rtl/cmo_dcache_responder_onehot_to_bin.sv
// Hit-way encoder: binary index of the lowest set bit, so a malformed
// multi-hot vector still resolves to a single deterministic way.
module cmo_dcache_responder_onehot_to_bin #(
    parameter  int unsigned ONEHOT_WIDTH = 4,
    localparam int unsigned BIN_WIDTH    = (ONEHOT_WIDTH > 1) ? $clog2(ONEHOT_WIDTH) : 1
) (
    input  logic [ONEHOT_WIDTH-1:0] i_onehot,
    output logic [BIN_WIDTH-1:0]    o_bin
);

    always_comb begin
        o_bin = '0;
        for (int i = ONEHOT_WIDTH - 1; i >= 0; i--) begin
            if (i_onehot[i]) o_bin = BIN_WIDTH'(i);
        end
    end

endmodule

// File: rtl/cmo_dcache_responder.sv
// CMO responder inside the L1 D-cache: runs CLEAN/FLUSH/INVAL/ZERO on one line
// through the tag-lookup, writeback and update ports, and acks hints directly.
module cmo_dcache_responder
    import cmo_dcache_responder_pkg::*;
#(
    parameter int unsigned NUM_WAYS    = 4,
    parameter int unsigned INDEX_WIDTH = 8,
    parameter int unsigned TAG_WIDTH   = 44,
    parameter int unsigned LINE_OFFSET = 4
) (
    input  logic                   clk_i,
    input  logic                   rst_ni,
    input  cmo_req_t               cmo_req_i,
    output cmo_resp_t              cmo_resp_o,
    output logic                   tag_req_o,
    input  logic                   tag_gnt_i,
    output logic [INDEX_WIDTH-1:0] tag_index_o,
    output logic [TAG_WIDTH-1:0]   tag_tag_o,
    input  logic [NUM_WAYS-1:0]    hit_way_i,
    input  logic [NUM_WAYS-1:0]    dirty_i,
    output logic                   wb_req_o,
    input  logic                   wb_gnt_i,
    output logic                   wb_zero_o,
    output xlen_t                  wb_addr_o,
    output logic [NUM_WAYS-1:0]    wb_way_o,
    input  logic                   wb_done_i,
    output logic                   upd_req_o,
    input  logic                   upd_gnt_i,
    output logic [INDEX_WIDTH-1:0] upd_index_o,
    output logic [NUM_WAYS-1:0]    upd_way_o,
    output logic                   upd_valid_o,
    output logic                   upd_dirty_o,
    output logic                   upd_zero_o,
    output logic                   busy_o
);

    localparam int unsigned WAY_IDX_W = (NUM_WAYS > 1) ? $clog2(NUM_WAYS) : 1;
    localparam xlen_t       LINE_MASK = ~((xlen_t'(1) << LINE_OFFSET) - xlen_t'(1));

    typedef enum logic [2:0] {
        S_IDLE, S_LOOKUP, S_CHECK, S_WB_REQ, S_WB_WAIT, S_UPDATE, S_ACK
    } state_t;

    state_t                   r_state;
    state_t                   w_state_next;
    logic [TRANS_ID_BITS-1:0] r_trans_id;
    xlen_t                    r_addr;
    cmo_t                     r_op;
    logic                     r_hit;
    logic [WAY_IDX_W-1:0]     r_hit_idx;
    logic [WAY_IDX_W-1:0]     w_hit_idx;
    logic                     w_accept;
    logic                     w_hit;
    logic                     w_dirty;
    logic [NUM_WAYS-1:0]      w_way_onehot;
    dcache_cmo_upd_t          w_upd;

    cmo_dcache_responder_onehot_to_bin #(
        .ONEHOT_WIDTH (NUM_WAYS)
    ) u_hit_enc (
        .i_onehot (hit_way_i),
        .o_bin    (w_hit_idx)
    );

    assign w_accept     = (r_state == S_IDLE) && cmo_req_i.req;
    assign w_hit        = |hit_way_i;
    assign w_dirty      = dirty_i[w_hit_idx];
    assign w_way_onehot = NUM_WAYS'(1) << r_hit_idx;
    assign w_upd        = cmo_upd_decode(r_op);

    always_ff @(posedge clk_i) begin
        if (!rst_ni) r_state <= S_IDLE;
        else         r_state <= w_state_next;
    end

    // Request buffer; the hit way is captured once, in CHECK.
    always_ff @(posedge clk_i) begin
        if (!rst_ni) begin
            r_trans_id <= '0;
            r_addr     <= '0;
            r_op       <= CMO_NONE;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
        end else if (w_accept) begin
            r_trans_id <= cmo_req_i.trans_id;
            r_addr     <= cmo_req_i.address & LINE_MASK;
            r_op       <= cmo_req_i.cmo_op;
            r_hit      <= 1'b0;
            r_hit_idx  <= '0;
        end else if (r_state == S_CHECK) begin
            r_hit      <= w_hit;
            r_hit_idx  <= w_hit_idx;
        end
    end

    always_comb begin
        w_state_next = r_state;
        case (r_state)
            S_IDLE: begin
                if (w_accept) w_state_next = cmo_is_hint(cmo_req_i.cmo_op) ? S_ACK : S_LOOKUP;
            end
            S_LOOKUP: if (tag_gnt_i) w_state_next = S_CHECK;
            S_CHECK: begin
                if (!w_hit) begin
                    w_state_next = (r_op == CMO_ZERO) ? S_WB_REQ : S_ACK;
                end else begin
                    case (r_op)
                        CMO_CLEAN:           w_state_next = w_dirty ? S_WB_REQ : S_ACK;
                        CMO_FLUSH:           w_state_next = w_dirty ? S_WB_REQ : S_UPDATE;
                        CMO_INVAL, CMO_ZERO: w_state_next = S_UPDATE;
                        default:             w_state_next = S_ACK;
                    endcase
                end
            end
            S_WB_REQ:  if (wb_gnt_i) w_state_next = S_WB_WAIT;
            // Only a ZERO miss reaches writeback without a hit, and it needs no update.
            S_WB_WAIT: if (wb_done_i) w_state_next = r_hit ? S_UPDATE : S_ACK;
            S_UPDATE:  if (upd_gnt_i) w_state_next = S_ACK;
            S_ACK:     w_state_next = S_IDLE;
            default:   w_state_next = S_IDLE;
        endcase
    end

    always_comb begin
        cmo_resp_o  = '0;
        tag_req_o   = 1'b0;
        tag_index_o = '0;
        tag_tag_o   = '0;
        wb_req_o    = 1'b0;
        wb_zero_o   = 1'b0;
        wb_addr_o   = '0;
        wb_way_o    = '0;
        upd_req_o   = 1'b0;
        upd_index_o = '0;
        upd_way_o   = '0;
        upd_valid_o = 1'b0;
        upd_dirty_o = 1'b0;
        upd_zero_o  = 1'b0;
        busy_o      = (r_state != S_IDLE);
        case (r_state)
            S_IDLE: cmo_resp_o.req_ready = 1'b1;
            S_LOOKUP: begin
                tag_req_o   = 1'b1;
                tag_index_o = r_addr[LINE_OFFSET +: INDEX_WIDTH];
                tag_tag_o   = r_addr[LINE_OFFSET + INDEX_WIDTH +: TAG_WIDTH];
            end
            S_WB_REQ: begin
                wb_req_o  = 1'b1;
                wb_zero_o = !r_hit;
                wb_addr_o = r_addr;
                wb_way_o  = r_hit ? w_way_onehot : '0;
            end
            S_UPDATE: begin
                upd_req_o   = 1'b1;
                upd_index_o = r_addr[LINE_OFFSET +: INDEX_WIDTH];
                upd_way_o   = w_way_onehot;
                upd_valid_o = w_upd.valid;
                upd_dirty_o = w_upd.dirty;
                upd_zero_o  = w_upd.zero;
            end
            S_ACK: begin
                cmo_resp_o.ack      = 1'b1;
                cmo_resp_o.trans_id = r_trans_id;
            end
            default: ;
        endcase
    end

    assert property (@(posedge clk_i) disable iff (!rst_ni)
                     (r_state == S_CHECK) |-> $onehot0(hit_way_i));

endmodule

// File: tb/tb_cmo_dcache_responder.sv
// Directed self-checking bench for cmo_dcache_responder.
module tb_cmo_dcache_responder;
    import cmo_dcache_responder_pkg::*;

    logic        clk_i;
    logic        rst_ni;
    cmo_req_t    req;
    cmo_resp_t   resp;
    logic        tag_req_o, tag_gnt_i;
    logic [7:0]  tag_index_o;
    logic [43:0] tag_tag_o;
    logic [3:0]  hit_way_i, dirty_i;
    logic        wb_req_o, wb_gnt_i, wb_zero_o, wb_done_i;
    xlen_t       wb_addr_o;
    logic [3:0]  wb_way_o;
    logic        upd_req_o, upd_gnt_i;
    logic [7:0]  upd_index_o;
    logic [3:0]  upd_way_o;
    logic        upd_valid_o, upd_dirty_o, upd_zero_o, busy_o;

    int checks = 0;
    int failures = 0;

    int          obs_lat;
    logic        obs_timeout, obs_rdy_c1, obs_ack_again;
    logic        obs_saw_tag, obs_saw_wb, obs_saw_upd;
    logic [3:0]  obs_ack_id;
    logic [7:0]  obs_tag_index, obs_upd_index;
    logic [43:0] obs_tag_tag;
    xlen_t       obs_wb_addr;
    logic [3:0]  obs_wb_way, obs_upd_way;
    logic        obs_wb_zero, obs_upd_valid, obs_upd_dirty, obs_upd_zero;

    cmo_dcache_responder dut (
        .clk_i       (clk_i),
        .rst_ni      (rst_ni),
        .cmo_req_i   (req),
        .cmo_resp_o  (resp),
        .tag_req_o   (tag_req_o),
        .tag_gnt_i   (tag_gnt_i),
        .tag_index_o (tag_index_o),
        .tag_tag_o   (tag_tag_o),
        .hit_way_i   (hit_way_i),
        .dirty_i     (dirty_i),
        .wb_req_o    (wb_req_o),
        .wb_gnt_i    (wb_gnt_i),
        .wb_zero_o   (wb_zero_o),
        .wb_addr_o   (wb_addr_o),
        .wb_way_o    (wb_way_o),
        .wb_done_i   (wb_done_i),
        .upd_req_o   (upd_req_o),
        .upd_gnt_i   (upd_gnt_i),
        .upd_index_o (upd_index_o),
        .upd_way_o   (upd_way_o),
        .upd_valid_o (upd_valid_o),
        .upd_dirty_o (upd_dirty_o),
        .upd_zero_o  (upd_zero_o),
        .busy_o      (busy_o)
    );

    initial clk_i = 1'b0;
    always #5 clk_i = ~clk_i;

    // Issues one request at a negedge and plays the cache side until the ack.
    task automatic drive_op(input cmo_t op, input logic [3:0] id, input xlen_t addr, input int gnt_dly,
                            input logic [3:0] hit, input logic [3:0] dirty, input int done_dly);
        int tag_cnt;
        int wb_cnt;
        bit gnt_given;
        bit wb_pending;
        bit done;
        tag_cnt = 0; wb_cnt = 0; gnt_given = 0; wb_pending = 0; done = 0;
        obs_lat = 0; obs_rdy_c1 = 1'b1; obs_ack_again = 1'b0; obs_ack_id = '0;
        obs_saw_tag = 1'b0; obs_saw_wb = 1'b0; obs_saw_upd = 1'b0;
        obs_tag_index = '0; obs_tag_tag = '0; obs_wb_addr = '0; obs_wb_way = '0; obs_wb_zero = 1'b0;
        obs_upd_index = '0; obs_upd_way = '0; obs_upd_valid = 1'b0; obs_upd_dirty = 1'b0; obs_upd_zero = 1'b0;
        req.req = 1'b1; req.trans_id = id; req.address = addr; req.cmo_op = op;
        for (int cyc = 1; cyc <= 200 && !done; cyc++) begin
            @(negedge clk_i);
            req.req = 1'b0; tag_gnt_i = 1'b0; hit_way_i = '0; dirty_i = '0;
            wb_gnt_i = 1'b0; wb_done_i = 1'b0; upd_gnt_i = 1'b0;
            if (cyc == 1) obs_rdy_c1 = resp.req_ready;
            if (gnt_given) begin
                hit_way_i = hit; dirty_i = dirty; gnt_given = 0;
            end
            if (tag_req_o) begin
                obs_saw_tag = 1'b1; obs_tag_index = tag_index_o; obs_tag_tag = tag_tag_o;
                tag_cnt++;
                if (tag_cnt > gnt_dly) begin tag_gnt_i = 1'b1; gnt_given = 1; end
            end
            if (wb_req_o) begin
                obs_saw_wb = 1'b1; obs_wb_addr = wb_addr_o; obs_wb_way = wb_way_o; obs_wb_zero = wb_zero_o;
                wb_gnt_i = 1'b1; wb_pending = 1; wb_cnt = 0;
            end else if (wb_pending) begin
                wb_cnt++;
                if (wb_cnt >= done_dly) begin wb_done_i = 1'b1; wb_pending = 0; end
            end
            if (upd_req_o) begin
                obs_saw_upd = 1'b1; obs_upd_index = upd_index_o; obs_upd_way = upd_way_o;
                obs_upd_valid = upd_valid_o; obs_upd_dirty = upd_dirty_o; obs_upd_zero = upd_zero_o;
                upd_gnt_i = 1'b1;
            end
            if (resp.ack) begin
                obs_ack_id = resp.trans_id; obs_lat = cyc; done = 1;
            end
        end
        obs_timeout = !done;
        @(negedge clk_i);
        tag_gnt_i = 1'b0; hit_way_i = '0; dirty_i = '0; wb_gnt_i = 1'b0; wb_done_i = 1'b0; upd_gnt_i = 1'b0;
        obs_ack_again = resp.ack;
    endtask

    task automatic test_reset();
        rst_ni = 1'b0;
        req = '0;
        tag_gnt_i = 1'b0; hit_way_i = '0; dirty_i = '0;
        wb_gnt_i = 1'b0; wb_done_i = 1'b0; upd_gnt_i = 1'b0;
        repeat (2) @(negedge clk_i);
        checks++; if (resp.req_ready !== 1'b1) begin failures++; $display("FAIL rst_ready got=%b exp=1", resp.req_ready); end
        checks++; if (resp.ack !== 1'b0) begin failures++; $display("FAIL rst_ack got=%b exp=0", resp.ack); end
        checks++; if ({tag_req_o, wb_req_o, upd_req_o, busy_o} !== 4'b0000) begin failures++;
            $display("FAIL rst_reqs got=%b exp=0000", {tag_req_o, wb_req_o, upd_req_o, busy_o}); end
        checks++; if ({wb_addr_o, tag_tag_o, upd_way_o, wb_way_o} !== '0) begin failures++;
            $display("FAIL rst_payload got=%h exp=0", {wb_addr_o, tag_tag_o, upd_way_o, wb_way_o}); end
        rst_ni = 1'b1;
        @(negedge clk_i);
    endtask

    task automatic test_hint();
        drive_op(CMO_PREFETCH_W, 4'd5, 64'h8000_0013, 0, 4'b0000, 4'b0000, 1);
        checks++; if (obs_rdy_c1 !== 1'b0) begin failures++; $display("FAIL hint_ready_drop got=%b exp=0", obs_rdy_c1); end
        checks++; if (obs_timeout || obs_lat != 1) begin failures++; $display("FAIL hint_latency got=%0d exp=1", obs_lat); end
        checks++; if (obs_ack_id !== 4'd5) begin failures++; $display("FAIL hint_id got=%0d exp=5", obs_ack_id); end
        checks++; if ({obs_saw_tag, obs_saw_wb, obs_saw_upd} !== 3'b000) begin failures++;
            $display("FAIL hint_no_reqs got=%b exp=000", {obs_saw_tag, obs_saw_wb, obs_saw_upd}); end
        checks++; if (obs_ack_again !== 1'b0) begin failures++; $display("FAIL hint_single_ack got=%b exp=0", obs_ack_again); end
    endtask

    task automatic test_clean_dirty();
        drive_op(CMO_CLEAN, 4'd2, 64'h8000_0040, 2, 4'b0100, 4'b0100, 10);
        checks++; if (obs_tag_index !== 8'h04 || obs_tag_tag !== 44'h8_0000) begin failures++;
            $display("FAIL clean_tag got=%h/%h exp=04/80000", obs_tag_index, obs_tag_tag); end
        checks++; if (!obs_saw_wb || obs_wb_addr !== 64'h8000_0040 || obs_wb_way !== 4'b0100 || obs_wb_zero !== 1'b0) begin
            failures++; $display("FAIL clean_wb got=%b %h %b %b exp=1 80000040 0100 0", obs_saw_wb, obs_wb_addr, obs_wb_way, obs_wb_zero); end
        checks++; if (!obs_saw_upd || {obs_upd_valid, obs_upd_dirty, obs_upd_zero} !== 3'b100 || obs_upd_way !== 4'b0100 || obs_upd_index !== 8'h04) begin
            failures++; $display("FAIL clean_upd got=%b %b %h exp=100 0100 04", {obs_upd_valid, obs_upd_dirty, obs_upd_zero}, obs_upd_way, obs_upd_index); end
        checks++; if (obs_timeout || obs_lat != 17 || obs_ack_id !== 4'd2) begin failures++;
            $display("FAIL clean_ack got=lat%0d id%0d exp=lat17 id2", obs_lat, obs_ack_id); end
        checks++; if (obs_ack_again !== 1'b0) begin failures++; $display("FAIL clean_single_ack got=%b exp=0", obs_ack_again); end
    endtask

    task automatic test_flush_clean();
        drive_op(CMO_FLUSH, 4'd7, 64'h8000_0120, 0, 4'b0001, 4'b0000, 1);
        checks++; if (obs_saw_wb !== 1'b0) begin failures++; $display("FAIL flush_no_wb got=%b exp=0", obs_saw_wb); end
        checks++; if (!obs_saw_upd || obs_upd_way !== 4'b0001 || {obs_upd_valid, obs_upd_dirty, obs_upd_zero} !== 3'b000 || obs_upd_index !== 8'h12) begin
            failures++; $display("FAIL flush_upd got=%b %b %h exp=0001 000 12", obs_upd_way, {obs_upd_valid, obs_upd_dirty, obs_upd_zero}, obs_upd_index); end
        checks++; if (obs_timeout || obs_lat != 4 || obs_ack_id !== 4'd7) begin failures++;
            $display("FAIL flush_ack got=lat%0d id%0d exp=lat4 id7", obs_lat, obs_ack_id); end
    endtask

    task automatic test_inval();
        drive_op(CMO_INVAL, 4'd3, 64'h8000_0200, 1, 4'b1000, 4'b1000, 1);
        checks++; if (obs_saw_wb !== 1'b0) begin failures++; $display("FAIL inval_no_wb got=%b exp=0", obs_saw_wb); end
        checks++; if (!obs_saw_upd || obs_upd_way !== 4'b1000 || {obs_upd_valid, obs_upd_dirty, obs_upd_zero} !== 3'b000) begin
            failures++; $display("FAIL inval_upd got=%b %b exp=1000 000", obs_upd_way, {obs_upd_valid, obs_upd_dirty, obs_upd_zero}); end
        checks++; if (obs_timeout || obs_lat != 5 || obs_ack_id !== 4'd3) begin failures++;
            $display("FAIL inval_ack got=lat%0d id%0d exp=lat5 id3", obs_lat, obs_ack_id); end
        drive_op(CMO_INVAL, 4'd4, 64'h8000_0200, 0, 4'b0000, 4'b1111, 1);
        checks++; if ({obs_saw_wb, obs_saw_upd} !== 2'b00) begin failures++;
            $display("FAIL inval_miss_reqs got=%b exp=00", {obs_saw_wb, obs_saw_upd}); end
        checks++; if (obs_timeout || obs_lat != 3 || obs_ack_id !== 4'd4) begin failures++;
            $display("FAIL inval_miss_ack got=lat%0d id%0d exp=lat3 id4", obs_lat, obs_ack_id); end
    endtask

    task automatic test_zero();
        drive_op(CMO_ZERO, 4'd10, 64'h8000_1000, 0, 4'b0000, 4'b0000, 1);
        checks++; if (!obs_saw_wb || obs_wb_zero !== 1'b1 || obs_wb_addr !== 64'h8000_1000 || obs_wb_way !== 4'b0000) begin
            failures++; $display("FAIL zero_miss_wb got=%b %b %h %b exp=1 1 80001000 0000", obs_saw_wb, obs_wb_zero, obs_wb_addr, obs_wb_way); end
        checks++; if (obs_saw_upd !== 1'b0 || obs_timeout || obs_lat != 5 || obs_ack_id !== 4'd10) begin failures++;
            $display("FAIL zero_miss_ack got=upd%b lat%0d id%0d exp=upd0 lat5 id10", obs_saw_upd, obs_lat, obs_ack_id); end
        drive_op(CMO_ZERO, 4'd11, 64'h8000_2087, 0, 4'b0010, 4'b0000, 1);
        checks++; if (obs_saw_wb !== 1'b0) begin failures++; $display("FAIL zero_hit_no_wb got=%b exp=0", obs_saw_wb); end
        checks++; if (!obs_saw_upd || obs_upd_way !== 4'b0010 || {obs_upd_valid, obs_upd_dirty, obs_upd_zero} !== 3'b111 || obs_upd_index !== 8'h08) begin
            failures++; $display("FAIL zero_hit_upd got=%b %b %h exp=0010 111 08", obs_upd_way, {obs_upd_valid, obs_upd_dirty, obs_upd_zero}, obs_upd_index); end
        checks++; if (obs_timeout || obs_ack_id !== 4'd11) begin failures++; $display("FAIL zero_hit_ack got=id%0d exp=id11", obs_ack_id); end
    endtask

    task automatic test_reset_mid();
        req.req = 1'b1; req.trans_id = 4'd9; req.address = 64'h8000_0040; req.cmo_op = CMO_CLEAN;
        @(negedge clk_i); req.req = 1'b0; tag_gnt_i = 1'b1;
        @(negedge clk_i); tag_gnt_i = 1'b0; hit_way_i = 4'b0100; dirty_i = 4'b0100;
        @(negedge clk_i); hit_way_i = '0; dirty_i = '0;
        checks++; if (wb_req_o !== 1'b1) begin failures++; $display("FAIL rstmid_wbreq got=%b exp=1", wb_req_o); end
        wb_gnt_i = 1'b1;
        @(negedge clk_i); wb_gnt_i = 1'b0;
        checks++; if ({busy_o, wb_req_o} !== 2'b10) begin failures++; $display("FAIL rstmid_wait got=%b exp=10", {busy_o, wb_req_o}); end
        rst_ni = 1'b0;
        @(negedge clk_i);
        checks++; if ({resp.req_ready, resp.ack, tag_req_o, wb_req_o, upd_req_o, busy_o} !== 6'b100000) begin failures++;
            $display("FAIL rstmid_outputs got=%b exp=100000", {resp.req_ready, resp.ack, tag_req_o, wb_req_o, upd_req_o, busy_o}); end
        rst_ni = 1'b1; wb_done_i = 1'b1;
        @(negedge clk_i); wb_done_i = 1'b0;
        checks++; if ({resp.req_ready, resp.ack, upd_req_o, busy_o} !== 4'b1000) begin failures++;
            $display("FAIL rstmid_no_ack got=%b exp=1000", {resp.req_ready, resp.ack, upd_req_o, busy_o}); end
    endtask

    task automatic test_back_to_back();
        req.req = 1'b1; req.trans_id = 4'd1; req.address = 64'h8000_0300; req.cmo_op = CMO_CLEAN;
        @(negedge clk_i); req.trans_id = 4'd2; tag_gnt_i = 1'b1;
        checks++; if (resp.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_lookup got=%b exp=0", resp.req_ready); end
        @(negedge clk_i); tag_gnt_i = 1'b0;
        checks++; if (resp.req_ready !== 1'b0) begin failures++; $display("FAIL b2b_ready_check got=%b exp=0", resp.req_ready); end
        @(negedge clk_i);
        checks++; if ({resp.ack, resp.trans_id, resp.req_ready} !== {1'b1, 4'd1, 1'b0}) begin failures++;
            $display("FAIL b2b_first_ack got=%b/%0d/%b exp=1/1/0", resp.ack, resp.trans_id, resp.req_ready); end
        @(negedge clk_i);
        checks++; if ({resp.req_ready, resp.ack, tag_req_o} !== 3'b100) begin failures++;
            $display("FAIL b2b_idle got=%b exp=100", {resp.req_ready, resp.ack, tag_req_o}); end
        @(negedge clk_i); req.req = 1'b0; tag_gnt_i = 1'b1;
        checks++; if ({tag_req_o, resp.req_ready} !== 2'b10) begin failures++;
            $display("FAIL b2b_second_accept got=%b exp=10", {tag_req_o, resp.req_ready}); end
        @(negedge clk_i); tag_gnt_i = 1'b0;
        @(negedge clk_i);
        checks++; if ({resp.ack, resp.trans_id} !== {1'b1, 4'd2}) begin failures++;
            $display("FAIL b2b_second_ack got=%b/%0d exp=1/2", resp.ack, resp.trans_id); end
        @(negedge clk_i);
    endtask

    initial begin
        test_reset();
        test_hint();
        test_clean_dirty();
        test_flush_clean();
        test_inval();
        test_zero();
        test_reset_mid();
        test_back_to_back();
        $display("TB_RESULT checks=%0d failures=%0d", checks, failures);
        $finish;
    end

    initial begin
        #200000;
        $display("FAIL watchdog got=timeout exp=finish");
        $fatal(1, "watchdog");
    end

endmodule

// File: doc/cmo_dcache_responder.md
Name: cmo_dcache_responder

Overview:
- Responder end of the CMO request/response interface, placed inside the L1 D-cache.
- Accepts one `cmo_req_t` at a time and runs CLEAN, FLUSH, INVAL or ZERO on one cache line, using the cache's tag-lookup, writeback and tag/data-update ports.
- Returns a single-cycle ack carrying the trans_id in `cmo_resp_t`.
- PREFETCH_R/W and CMO_NONE are accepted as hints and acked without touching the arrays.

Parameters:
- NUM_WAYS, 4, D-cache associativity.
- INDEX_WIDTH, 8, set index width.
- TAG_WIDTH, 44, tag width.
- LINE_OFFSET, 4, log2 of line size in bytes.

Ports:
- clk_i  in  1  clock.
- rst_ni  in  1  synchronous active-low reset.
- cmo_req_i  in  cmo_req_t  req, trans_id, address, cmo_op from the CMO functional unit.
- cmo_resp_o  out  cmo_resp_t  req_ready, ack, trans_id.
- tag_req_o  out  1  tag lookup request.
- tag_gnt_i  in  1  lookup granted; result is valid next cycle.
- tag_index_o  out  INDEX_WIDTH  lookup set.
- tag_tag_o  out  TAG_WIDTH  lookup tag.
- hit_way_i  in  NUM_WAYS  one-hot hit vector, valid the cycle after grant.
- dirty_i  in  NUM_WAYS  per-way dirty bits, same timing as hit_way_i.
- wb_req_o  out  1  writeback request.
- wb_gnt_i  in  1  writeback accepted.
- wb_zero_o  out  1  write a zero line to memory at wb address (no array read).
- wb_addr_o  out  riscv::xlen_t  line-aligned address.
- wb_way_o  out  NUM_WAYS  one-hot way to write back when wb_zero_o=0.
- wb_done_i  in  1  writeback complete.
- upd_req_o  out  1  tag/data update request.
- upd_gnt_i  in  1  update performed this cycle.
- upd_index_o  out  INDEX_WIDTH  update set.
- upd_way_o  out  NUM_WAYS  update way.
- upd_valid_o  out  1  new valid bit.
- upd_dirty_o  out  1  new dirty bit.
- upd_zero_o  out  1  also zero the data line.
- busy_o  out  1  FSM not IDLE; stalls miss-unit refills to the same set.

Behaviour:
- Reset (rst_ni low at clk edge):
  - FSM goes to IDLE and the request buffer clears.
  - All outputs read 0 except req_ready=1.
  - A reset mid-operation abandons the operation with no ack; outstanding cache/memory handshakes are reset with it.
- Accept:
  - req_ready=1 only in IDLE.
  - On req & req_ready, latch trans_id, line-aligned address (low LINE_OFFSET bits cleared) and cmo_op.
  - req_ready drops the next cycle.
- States and transitions:
  - IDLE: on accept, go to ACK for PREFETCH_R/W or NONE; otherwise go to LOOKUP.
  - LOOKUP: tag_req_o held until tag_gnt_i, then CHECK.
  - CHECK: sample hit_way_i/dirty_i and register the hit way. Next state:
    - miss and op≠ZERO → ACK.
    - miss and ZERO → WB_REQ with wb_zero_o=1.
    - hit, CLEAN/FLUSH, dirty → WB_REQ with wb_zero_o=0.
    - hit, CLEAN clean → ACK.
    - hit, FLUSH clean → UPDATE.
    - hit, INVAL → UPDATE (no writeback, dirty data discarded).
    - hit, ZERO → UPDATE.
  - WB_REQ: wb_req_o held until wb_gnt_i, then WB_WAIT.
  - WB_WAIT: on wb_done_i, next state:
    - CLEAN → UPDATE.
    - FLUSH → UPDATE.
    - ZERO-miss → ACK.
  - UPDATE: upd_req_o held until upd_gnt_i, then ACK. Update values by op:
    - CLEAN: valid=1, dirty=0.
    - FLUSH/INVAL: valid=0, dirty=0.
    - ZERO: valid=1, dirty=1, upd_zero_o=1.
  - ACK: ack=1 and trans_id=latched for exactly one cycle, then IDLE.
- The ack has no backpressure. The next request is accepted no earlier than the cycle after the ack.
- Latency:
  - Hint ops: accept cycle 0, ack cycle 1.
  - CLEAN miss with immediate grant: ack cycle 3.
- hit_way_i must be one-hot or zero; multi-hot is an assertion failure, and the lowest set bit is used.
- req asserted while busy is ignored (req_ready=0); the sender holds it.
- wb_*/upd_*/tag_* outputs are stable while their req is high.
- busy_o = (state≠IDLE).

Decomposition:
- The FSM state enum stays local.
- cmo_t, cmo_req_t and cmo_resp_t already live in ariane_pkg.
- Add DCACHE CMO update-type constants to ariane_pkg (or std_cache_pkg), so the cache controller decodes upd_valid/dirty/zero consistently.
- One sub-module: common_cells onehot_to_bin for hit-way encoding, where an index is needed.

Test Plan:
- PREFETCH_W, trans_id=5, addr 0x8000_0013 → req_ready low next cycle; ack=1 with trans_id=5 in cycle 1; no tag/wb/upd requests.
- CLEAN at 0x8000_0040, hit way 2 dirty; tag_gnt after 2 cycles; wb_done 10 cycles after grant → wb_addr=0x8000_0040, wb_way=4'b0100, wb_zero=0; then upd valid=1 dirty=0; single ack.
- FLUSH, hit way 0 clean → no wb_req; upd way 4'b0001 valid=0 dirty=0; ack with the correct trans_id.
- INVAL, hit way 3 dirty → no wb_req; upd valid=0; ack. Repeat as a miss → ack directly after CHECK.
- ZERO miss at 0x8000_1000 → wb_req with wb_zero=1, wb_addr=0x8000_1000. ZERO hit way 1 → upd_zero=1, dirty=1, valid=1.
- Reset asserted in WB_WAIT → next cycle all req outputs 0, req_ready=1, no ack. Back-to-back CLEANs → second accepted only after the first ack.
